// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared types, default sizes and helper functions for the
//               eight-source strict-priority interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

  localparam int N_DEFAULT    = 8;
  localparam int ID_W_DEFAULT = $clog2(N_DEFAULT);

  // Handshake states: waiting for a request, presenting irq, source in service
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  // Width of the ack-wait timer; kept at least one bit so a disabled
  // timeout (ACK_TIMEOUT == 0) still yields a legal vector
  function automatic int timer_w(input int ack_timeout);
    int w;
    w = $clog2(ack_timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/prio_enc_hi.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_hi
// Description : Combinational priority encoder. Reports the binary index of
//               the highest set bit of the input vector plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_hi
  import irq_ctrl_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec_i,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  // Ascending scan so the last (highest) set bit overrides lower ones
  always_comb begin
    id_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

  assign valid_o = |vec_i;

endmodule : prio_enc_hi
`default_nettype wire

// File: rtl/irq_priority_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_priority_controller
// Description : Eight-source strict-priority interrupt controller with
//               active-low request/enable lines, ack / in-service / EOI
//               handshake and an optional ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_n,
  input  logic [N-1:0]         mask,
  input  logic                 en_n,
  input  logic                 ack,
  input  logic                 eoi,
  output logic                 irq,
  output logic [$clog2(N)-1:0] irq_id,
  output logic                 gs_n,
  output logic                 busy,
  output logic                 timeout
);

  localparam int ID_W = $clog2(N);
  localparam int TW   = timer_w(ACK_TIMEOUT);
  // Timer value on which the wait expires; only meaningful when enabled
  localparam logic [TW-1:0] TLAST = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    act_q, act_d;
  logic            irq_q, irq_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [ID_W-1:0] win_id;
  logic            win_valid;

  prio_enc_hi #(
    .N    (N),
    .ID_W (ID_W)
  ) u_prio (
    .vec_i   (act_q),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  // Single sampling stage: a request counts only when low and not masked
  assign act_d = ~req_n & ~mask;

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      act_q     <= '0;
      irq_q     <= 1'b0;
      id_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  // Handshake FSM: arbitration in IDLE, ack wait in REQ, service until EOI
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    id_d      = id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        irq_d  = 1'b0;
        busy_d = 1'b0;
        if (!en_n && win_valid) begin
          id_d    = win_id;
          irq_d   = 1'b1;
          timer_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack beats an enable drop, which beats the timeout
        if (ack) begin
          irq_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SERV;
        end else if (en_n) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end else if ((ACK_TIMEOUT != 0) && (timer_q == TLAST)) begin
          irq_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      SERV: begin
        irq_d = 1'b0;
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign irq     = irq_q;
  assign irq_id  = id_q;
  assign gs_n    = ~|act_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule : irq_priority_controller
`default_nettype wire
